// File: rtl/ice_uart_rx.sv
// 8N1 UART receiver for the pico2-ice RX pin: 2-FF synchroniser, start-bit validation,
// 3-sample mid-bit majority voting and a 1-entry valid/ready holding register.
`timescale 1ns/1ps
module ice_uart_rx #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_12p0,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned H            = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = 3;
  localparam int unsigned DATA_W       = 8;

  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $fatal(1, "ice_uart_rx: CLKS_PER_BIT must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sync1;
  logic               r_sync2;
  logic [1:0]         r_samp;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BIT_W-1:0]   r_bit;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               w_good;
  logic               w_ferr;
  logic               w_rx_s;
  logic               w_maj;
  logic               w_decide;
  logic               w_wrap;
  logic               w_hs;

  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_ferr;
  logic               r_ovr;
  logic               r_busy;

  assign w_rx_s   = r_sync2;
  assign w_decide = (r_cnt == CNT_DEC);
  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
  assign w_hs     = r_valid & rx_ready;

  // Line synchroniser; idles high so reset cannot fake a start bit
  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // First two mid-bit samples; the third is the live rx_s at the decision count
  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= 2'b11;
    end else begin
      if (r_cnt == CNT_S0) r_samp[0] <= w_rx_s;
      if (r_cnt == CNT_S1) r_samp[1] <= w_rx_s;
    end
  end

  // FSM and datapath state registers
  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic; the counter free-runs per bit period and is parked at 0 outside a frame
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_wrap ? '0 : CNT_W'(r_cnt + CNT_W'(1));
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_decide && w_maj) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_wrap) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_decide) w_shift_nxt = {w_maj, r_shift[DATA_W-1:1]};
        if (w_wrap) begin
          if (r_bit == BIT_W'(DATA_W - 1)) w_state_nxt = S_STOP;
          else                              w_bit_nxt   = BIT_W'(r_bit + BIT_W'(1));
        end
      end
      S_STOP: begin
        if (w_decide) begin
          w_cnt_nxt = '0;
          if (w_maj) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register: a simultaneous handshake frees the slot for the new byte
  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_good) begin
        if (!r_valid || w_hs) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ice_uart_rx.sv
// Directed bench for ice_uart_rx: table of framed bytes at nominal and +/-3% baud,
// plus hand-written glitch, framing-error, overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ice_uart_rx;

  localparam int BCLK      = 104;
  localparam int BCLK_SLOW = 107;
  localparam int BCLK_FAST = 101;
  localparam int NV        = 11;

  typedef struct {
    logic [7:0] data;
    int         bclk;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_sent = 0;
  int got_n = 0;
  int n_rise = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  int valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_mem [64];
  int start_mem [64];
  int rise_mem [64];

  ice_uart_rx dut (
    .clk_12p0 (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor sampled on the falling edge, between driver updates and the next active edge
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_mem[got_n[5:0]] <= rx_data;
      got_n <= got_n + 1;
    end
    if (rx_valid && !prev_valid) begin
      rise_mem[n_rise[5:0]] <= cyc;
      n_rise <= n_rise + 1;
    end
    if (rx_valid)  valid_cyc <= valid_cyc + 1;
    if (frame_err) ferr_n <= ferr_n + 1;
    if (overrun)   ovr_n <= ovr_n + 1;
    prev_valid <= rx_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int bclk, input logic stop);
    rx_in = 1'b0;
    start_mem[n_sent[5:0]] = cyc;
    n_sent++;
    tick(bclk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(bclk);
    end
    rx_in = stop;
    tick(bclk);
  endtask

  vec_t vec [NV];
  int g0, f0, o0, v0, s0, r0, lat;

  initial begin
    vec[0]  = '{8'hA5, BCLK,      300, 8'hA5};
    vec[1]  = '{8'h00, BCLK,      0,   8'h00};
    vec[2]  = '{8'hFF, BCLK,      0,   8'hFF};
    vec[3]  = '{8'h55, BCLK,      300, 8'h55};
    vec[4]  = '{8'h00, BCLK_SLOW, 0,   8'h00};
    vec[5]  = '{8'hFF, BCLK_SLOW, 0,   8'hFF};
    vec[6]  = '{8'h55, BCLK_SLOW, 300, 8'h55};
    vec[7]  = '{8'h00, BCLK_FAST, 0,   8'h00};
    vec[8]  = '{8'hFF, BCLK_FAST, 0,   8'hFF};
    vec[9]  = '{8'h55, BCLK_FAST, 300, 8'h55};
    vec[10] = '{8'h3C, BCLK,      300, 8'h3C};

    rst_n    = 1'b0;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
    tick(5);
    @(negedge clk);
    chk("reset rx_data",   32'(rx_data), 0);
    chk("reset rx_valid",  32'(rx_valid), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset overrun",   32'(overrun), 0);
    chk("reset busy",      32'(busy), 0);
    tick(1);
    rst_n = 1'b1;
    tick(10);

    // Table: nominal single frame, then back-to-back groups at nominal, -3% and +3% baud
    g0 = got_n; f0 = ferr_n; o0 = ovr_n; v0 = valid_cyc; s0 = n_sent; r0 = n_rise;
    for (int i = 0; i < NV; i++) begin
      send_byte(vec[i].data, vec[i].bclk, 1'b1);
      tick(vec[i].gap);
    end
    tick(300);
    chk("table byte count", got_n - g0, NV);
    for (int i = 0; i < NV; i++)
      chk($sformatf("table byte %0d", i), 32'(got_mem[(g0 + i) % 64]), 32'(vec[i].exp));
    chk("table frame_err", ferr_n - f0, 0);
    chk("table overrun", ovr_n - o0, 0);
    chk("table valid cycles", valid_cyc - v0, NV);
    lat = rise_mem[r0 % 64] - start_mem[s0 % 64];
    chk("latency near 994", 32'((lat >= 992) && (lat <= 995)), 1);

    // Short low glitch must be rejected in START
    g0 = got_n; f0 = ferr_n;
    rx_in = 1'b0;
    tick(20);
    chk("glitch busy high", 32'(busy), 1);
    rx_in = 1'b1;
    for (int k = 0; k < 54; k++) begin
      if (!busy) break;
      tick(1);
    end
    chk("glitch busy dropped", 32'(busy), 0);
    tick(200);
    chk("glitch no valid", got_n - g0, 0);
    chk("glitch no frame_err", ferr_n - f0, 0);

    // Stop bit low, then line held low
    g0 = got_n; f0 = ferr_n; o0 = ovr_n;
    send_byte(8'h3C, BCLK, 1'b0);
    tick(300);
    chk("break busy held", 32'(busy), 1);
    chk("break frame_err once", ferr_n - f0, 1);
    chk("break no valid", got_n - g0, 0);
    chk("break no overrun", ovr_n - o0, 0);
    rx_in = 1'b1;
    tick(5);
    chk("break busy released", 32'(busy), 0);

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    g0 = got_n; f0 = ferr_n; o0 = ovr_n;
    send_byte(8'h11, BCLK, 1'b1);
    tick(50);
    send_byte(8'h22, BCLK, 1'b1);
    tick(100);
    @(negedge clk);
    chk("overrun valid held", 32'(rx_valid), 1);
    chk("overrun old byte kept", 32'(rx_data), 32'h11);
    chk("overrun pulse once", ovr_n - o0, 1);
    chk("overrun nothing consumed", got_n - g0, 0);
    tick(1);
    rx_ready = 1'b1;
    tick(3);
    chk("overrun consumed count", got_n - g0, 1);
    chk("overrun consumed byte", 32'(got_mem[g0 % 64]), 32'h11);
    chk("overrun valid cleared", 32'(rx_valid), 0);
    chk("overrun no frame_err", ferr_n - f0, 0);

    // Reset during data bit 4 of 0xF0 (start and bits 0..3 are all low)
    g0 = got_n; f0 = ferr_n; o0 = ovr_n;
    rx_in = 1'b0;
    tick(5 * BCLK + 50);
    chk("pre-reset busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset rx_data", 32'(rx_data), 0);
    chk("midreset rx_valid", 32'(rx_valid), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset frame_err", 32'(frame_err), 0);
    chk("midreset overrun", 32'(overrun), 0);
    tick(3);
    rx_in = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(20);
    send_byte(8'h81, BCLK, 1'b1);
    tick(300);
    chk("post-reset count", got_n - g0, 1);
    chk("post-reset byte", 32'(got_mem[g0 % 64]), 32'h81);
    chk("post-reset no frame_err", ferr_n - f0, 0);
    chk("post-reset no overrun", ovr_n - o0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
